// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS opcode/funct constants, Tuse/Tnew encoding and hazard helpers
// for the D-stage stall controller.
package hazard_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_ADDIU = 6'h09;

   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // Tuse/Tnew in cycles; T_NONE marks "not read" / "not written".
   typedef logic [1:0] tval_t;
   localparam tval_t T_NONE = 2'd3;

   // Register-register ALU group: add..nor, slt, sltu.
   function automatic logic is_r_alu(input logic [5:0] funct);
      return (funct[5:3] == 3'b100) || (funct[5:1] == 5'b10101);
   endfunction

   function automatic logic is_div_funct(input logic [5:0] funct);
      return (funct == FN_DIV) || (funct == FN_DIVU);
   endfunction

   // A producer still computing its result when the consumer needs it.
   function automatic logic raw_hit(input logic [4:0] dest, input tval_t tnew,
                                    input logic [4:0] src,  input tval_t tuse);
      return (dest != 5'd0) && (dest == src) && (tnew > tuse);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_instr_class.sv
// Decodes one instruction word into its register operands, Tuse/Tnew timing
// and multiply/divide class flags; instantiated once per pipeline stage.
module instr_class
   import hazard_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  dest,
   output tval_t       tuse_rs,
   output tval_t       tuse_rt,
   output tval_t       tnew_e,
   output tval_t       tnew_m,
   output logic        is_md_start,
   output logic        is_md_any
);

   logic [5:0] opcode;
   logic [5:0] funct;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      rs          = instr[25:21];
      rt          = instr[20:16];
      dest        = 5'd0;
      tuse_rs     = T_NONE;
      tuse_rt     = T_NONE;
      tnew_e      = T_NONE;
      tnew_m      = 2'd0;
      is_md_start = 1'b0;
      is_md_any   = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  tuse_rs     = 2'd1;
                  tuse_rt     = 2'd1;
                  is_md_start = 1'b1;
                  is_md_any   = 1'b1;
               end
               FN_MFHI, FN_MFLO: begin
                  dest      = instr[15:11];
                  tnew_e    = 2'd1;
                  is_md_any = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  tuse_rs   = 2'd1;
                  is_md_any = 1'b1;
               end
               FN_JR: tuse_rs = 2'd0;
               FN_JALR: begin
                  tuse_rs = 2'd0;
                  dest    = instr[15:11];
                  tnew_e  = 2'd0;
               end
               default: begin
                  // Shifts (including the all-zero nop) fall outside this group.
                  if (is_r_alu(funct)) begin
                     tuse_rs = 2'd1;
                     tuse_rt = 2'd1;
                     dest    = instr[15:11];
                     tnew_e  = 2'd1;
                  end
               end
            endcase
         end
         OP_LW: begin
            tuse_rs = 2'd1;
            dest    = instr[20:16];
            tnew_e  = 2'd2;
            tnew_m  = 2'd1;
         end
         OP_SW: begin
            tuse_rs = 2'd1;
            tuse_rt = 2'd2;
         end
         OP_BEQ, OP_BNE: begin
            tuse_rs = 2'd0;
            tuse_rt = 2'd0;
         end
         OP_JAL: begin
            dest   = 5'd31;
            tnew_e = 2'd0;
         end
         OP_LUI: begin
            dest   = instr[20:16];
            tnew_e = 2'd1;
         end
         OP_ORI, OP_ADDIU: begin
            tuse_rs = 2'd1;
            dest    = instr[20:16];
            tnew_e  = 2'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall controller: Tuse/Tnew RAW detection against E and M plus a
// multiply/divide busy tracker; freezes F/D and bubbles E on a stall.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4,
   parameter int MDU_EN      = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] IRD,
   input  logic [31:0] IRE,
   input  logic [31:0] IRM,
   output logic        PauseF,
   output logic        PauseD,
   output logic        ClearE,
   output logic        MdBusy
);

   logic [4:0] d_rs, d_rt, d_dest, e_rs, e_rt, e_dest, m_rs, m_rt, m_dest;
   tval_t      d_tuse_rs, d_tuse_rt, d_tnew_e, d_tnew_m;
   tval_t      e_tuse_rs, e_tuse_rt, e_tnew_e, e_tnew_m;
   tval_t      m_tuse_rs, m_tuse_rt, m_tnew_e, m_tnew_m;
   logic       d_start, d_md, e_start, e_md, m_start, m_md;
   logic       raw_stall, md_busy, stall;

   instr_class u_cls_d (
      .instr(IRD), .rs(d_rs), .rt(d_rt), .dest(d_dest),
      .tuse_rs(d_tuse_rs), .tuse_rt(d_tuse_rt), .tnew_e(d_tnew_e), .tnew_m(d_tnew_m),
      .is_md_start(d_start), .is_md_any(d_md)
   );

   instr_class u_cls_e (
      .instr(IRE), .rs(e_rs), .rt(e_rt), .dest(e_dest),
      .tuse_rs(e_tuse_rs), .tuse_rt(e_tuse_rt), .tnew_e(e_tnew_e), .tnew_m(e_tnew_m),
      .is_md_start(e_start), .is_md_any(e_md)
   );

   instr_class u_cls_m (
      .instr(IRM), .rs(m_rs), .rt(m_rt), .dest(m_dest),
      .tuse_rs(m_tuse_rs), .tuse_rt(m_tuse_rt), .tnew_e(m_tnew_e), .tnew_m(m_tnew_m),
      .is_md_start(m_start), .is_md_any(m_md)
   );

   // Each stage only needs part of its decode; the rest is deliberately dropped.
   logic unused_bits;
   assign unused_bits = ^{d_dest, d_tnew_e, d_tnew_m, d_start,
                          e_rs, e_rt, e_tuse_rs, e_tuse_rt, e_tnew_m, e_md,
                          m_rs, m_rt, m_tuse_rs, m_tuse_rt, m_tnew_e, m_start, m_md};

   assign raw_stall = raw_hit(e_dest, e_tnew_e, d_rs, d_tuse_rs)
                    | raw_hit(e_dest, e_tnew_e, d_rt, d_tuse_rt)
                    | raw_hit(m_dest, m_tnew_m, d_rs, d_tuse_rs)
                    | raw_hit(m_dest, m_tnew_m, d_rt, d_tuse_rt);

   generate
      if (MDU_EN != 0) begin : g_mdu
         localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
         localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

         logic [CNT_W-1:0] cnt;

         // A start in E always reloads, so the newest operation defines the wait.
         always_ff @(posedge Clk) begin
            // NOTE: reset is sampled on the clock edge here; state updates use <= only.
            if (!Reset) begin
               cnt <= '0;
            end else if (e_start) begin
               cnt <= is_div_funct(IRE[5:0]) ? DIV_LOAD : MULT_LOAD;
            end else if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end
         end

         assign md_busy = e_start | (cnt != '0);
      end else begin : g_no_mdu
         logic unused_start;
         assign unused_start = e_start;
         assign md_busy      = 1'b0;
      end
   endgenerate

   assign stall  = Reset & (raw_stall | (md_busy & d_md));
   assign PauseF = stall;
   assign PauseD = stall;
   assign ClearE = stall;
   assign MdBusy = Reset & md_busy;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed load-use/branch/store/MDU/reset scenarios followed by randomized
// instruction triples checked against a behavioural Tuse/Tnew model.
module tb_hazard_stall_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] IRD, IRE, IRM;
   logic        PauseF, PauseD, ClearE, MdBusy;
   logic        n_pauseF, n_pauseD, n_clearE, n_mdBusy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 Clk = ~Clk;

   hazard_stall_ctrl dut (
      .Clk(Clk), .Reset(Reset), .IRD(IRD), .IRE(IRE), .IRM(IRM),
      .PauseF(PauseF), .PauseD(PauseD), .ClearE(ClearE), .MdBusy(MdBusy)
   );

   hazard_stall_ctrl #(.MDU_EN(0)) dut_nomdu (
      .Clk(Clk), .Reset(Reset), .IRD(IRD), .IRE(IRE), .IRM(IRM),
      .PauseF(n_pauseF), .PauseD(n_pauseD), .ClearE(n_clearE), .MdBusy(n_mdBusy)
   );

   // Instruction kinds the random generator picks from, with their timing
   // attributes written down directly from the Tuse/Tnew rules.
   typedef enum int {
      K_NOP, K_ADDU, K_OR, K_SLT, K_ORI, K_ADDIU, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
      K_JAL, K_JR, K_JALR, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO,
      K_MTHI, K_MTLO, K_UNK, K_COUNT
   } kind_e;

   typedef struct {
      logic [31:0] w;
      int rs, rt, dest;
      int tuse_rs, tuse_rt, tnew_e, tnew_m;
      bit md_any, md_start, is_div;
   } ins_t;

   function automatic ins_t mk(kind_e k, logic [4:0] s, logic [4:0] t, logic [4:0] d,
                               logic [15:0] imm);
      ins_t r;
      r.w = 32'h0; r.rs = int'(s); r.rt = int'(t); r.dest = 0;
      r.tuse_rs = 3; r.tuse_rt = 3; r.tnew_e = 0; r.tnew_m = 0;
      r.md_any = 0; r.md_start = 0; r.is_div = 0;
      case (k)
         K_ADDU, K_OR, K_SLT: begin
            r.w = {6'h00, s, t, d, 5'd0, (k == K_ADDU) ? 6'h21 : (k == K_OR) ? 6'h25 : 6'h2a};
            r.tuse_rs = 1; r.tuse_rt = 1; r.dest = int'(d); r.tnew_e = 1;
         end
         K_ORI, K_ADDIU: begin
            r.w = {(k == K_ORI) ? 6'h0d : 6'h09, s, t, imm};
            r.tuse_rs = 1; r.dest = int'(t); r.tnew_e = 1;
         end
         K_LUI: begin
            r.w = {6'h0f, 5'd0, t, imm}; r.dest = int'(t); r.tnew_e = 1;
         end
         K_LW: begin
            r.w = {6'h23, s, t, imm};
            r.tuse_rs = 1; r.dest = int'(t); r.tnew_e = 2; r.tnew_m = 1;
         end
         K_SW: begin
            r.w = {6'h2b, s, t, imm}; r.tuse_rs = 1; r.tuse_rt = 2;
         end
         K_BEQ, K_BNE: begin
            r.w = {(k == K_BEQ) ? 6'h04 : 6'h05, s, t, imm}; r.tuse_rs = 0; r.tuse_rt = 0;
         end
         K_JAL:  begin r.w = {6'h03, 10'(imm), imm}; r.dest = 31; end
         K_JR:   begin r.w = {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h08}; r.tuse_rs = 0; end
         K_JALR: begin r.w = {6'h00, s, 5'd0, d, 5'd0, 6'h09}; r.tuse_rs = 0; r.dest = int'(d); end
         K_MULT, K_MULTU, K_DIV, K_DIVU: begin
            r.w = {6'h00, s, t, 10'd0,
                   (k == K_MULT) ? 6'h18 : (k == K_MULTU) ? 6'h19 : (k == K_DIV) ? 6'h1a : 6'h1b};
            r.tuse_rs = 1; r.tuse_rt = 1; r.md_any = 1; r.md_start = 1;
            r.is_div = (k == K_DIV) || (k == K_DIVU);
         end
         K_MFHI, K_MFLO: begin
            r.w = {16'h0, d, 5'd0, (k == K_MFHI) ? 6'h10 : 6'h12};
            r.dest = int'(d); r.tnew_e = 1; r.md_any = 1;
         end
         K_MTHI, K_MTLO: begin
            r.w = {6'h00, s, 15'd0, (k == K_MTHI) ? 6'h11 : 6'h13};
            r.tuse_rs = 1; r.md_any = 1;
         end
         K_UNK: r.w = {6'h3f, s, t, d, 11'h0};
         default: r.w = 32'h0;
      endcase
      return r;
   endfunction

   function automatic ins_t rnd_ins();
      kind_e k;
      k = kind_e'($urandom_range(0, int'(K_COUNT) - 1));
      return mk(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom));
   endfunction

   // Producer with result ready in 'tnew' cycles vs. consumer d's needs.
   function automatic bit hit(int dest, int tnew, ins_t d);
      return (dest != 0) && (((dest == d.rs) && (tnew > d.tuse_rs)) ||
                             ((dest == d.rt) && (tnew > d.tuse_rt)));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_in(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                         input logic r);
      IRD = d; IRE = e; IRM = m; Reset = r;
   endtask

   task automatic chk_stall(input string tag, input logic exp);
      check({tag, "_pausef"}, 32'(PauseF), 32'(exp));
      check({tag, "_paused"}, 32'(PauseD), 32'(exp));
      check({tag, "_cleare"}, 32'(ClearE), 32'(exp));
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Mimics the pipeline around a multiply/divide start with mflo waiting in D
   // and counts how many consecutive cycles the controller holds it.
   task automatic run_md(input string tag, input logic [31:0] start_w, input int exp_cycles);
      logic [31:0] d, e, m;
      int n;
      bit done;
      d = 32'h00001812; e = start_w; m = 32'h0; n = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         set_in(d, e, m, 1'b1);
         @(negedge Clk);
         if (PauseF) begin
            n++;
            m = e;
            e = 32'h0;
         end else begin
            done = 1;
         end
         tick();
      end
      check(tag, 32'(n), 32'(exp_cycles));
   endtask

   ins_t cd, ce, cm;
   bit   rst_r, busy_m, raw_m, have_s;
   int   last_s, last_len, cyc;

   initial begin
      set_in(32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      @(negedge Clk);
      chk_stall("reset_idle", 1'b0);
      check("reset_idle_busy", 32'(MdBusy), 32'h0);
      tick();

      // Load-use: lw $1 in E vs add reading $1.
      set_in(32'h00241820, 32'h8C410000, 32'h0, 1'b1);
      @(negedge Clk); chk_stall("loaduse_e", 1'b1); tick();
      set_in(32'h00241820, 32'h0, 32'h8C410000, 1'b1);
      @(negedge Clk); chk_stall("loaduse_m", 1'b0); tick();

      // Branch compares in D.
      set_in(32'h10400003, 32'h00441021, 32'h0, 1'b1);
      @(negedge Clk); chk_stall("branch_e", 1'b1); tick();
      set_in(32'h10400003, 32'h0, 32'h00441021, 1'b1);
      @(negedge Clk); chk_stall("branch_m", 1'b0); tick();

      // Store base vs store data against lw $5.
      set_in(32'hACA50000, 32'h8C050000, 32'h0, 1'b1);
      @(negedge Clk); chk_stall("sw_base_e", 1'b1); tick();
      set_in(32'hAC050000, 32'h8C050000, 32'h0, 1'b1);
      @(negedge Clk); chk_stall("sw_data_e", 1'b0); tick();
      set_in(32'hAC050000, 32'h0, 32'h8C050000, 1'b1);
      @(negedge Clk); chk_stall("sw_data_m", 1'b0); tick();
      set_in(32'hACA50000, 32'h0, 32'h8C050000, 1'b1);
      @(negedge Clk); chk_stall("sw_base_m", 1'b0); tick();

      // Register 0 never creates a dependence.
      set_in(32'h00001820, 32'h8C000000, 32'h0, 1'b1);
      @(negedge Clk); chk_stall("zero_reg", 1'b0); tick();

      // Multiply / divide wait lengths seen by an mflo.
      run_md("mult_mflo_cycles", 32'h00220018, 6);
      run_md("div_mflo_cycles", 32'h0022001a, 11);

      // Busy unit but unrelated instruction in D.
      set_in(32'h0, 32'h00220018, 32'h0, 1'b1);
      @(negedge Clk);
      check("start_busy", 32'(MdBusy), 32'h1);
      check("nomdu_start_busy", 32'(n_mdBusy), 32'h0);
      tick();
      set_in(32'h00241820, 32'h0, 32'h0, 1'b1);
      @(negedge Clk);
      chk_stall("busy_nonmd", 1'b0);
      check("busy_nonmd_busy", 32'(MdBusy), 32'h1);
      check("nomdu_busy", 32'(n_mdBusy), 32'h0);
      tick();

      // Reset mid-countdown: div loads 10, three idle edges bring it to 7.
      set_in(32'h0, 32'h0022001a, 32'h0, 1'b1);
      tick();
      set_in(32'h0, 32'h0, 32'h0, 1'b1);
      tick(); tick(); tick();
      @(negedge Clk);
      check("cnt7_busy", 32'(MdBusy), 32'h1);
      set_in(32'h00001812, 32'h00220018, 32'h0, 1'b0);
      @(negedge Clk);
      chk_stall("in_reset", 1'b0);
      check("in_reset_busy", 32'(MdBusy), 32'h0);
      tick();
      set_in(32'h00001812, 32'h0, 32'h0, 1'b1);
      @(negedge Clk);
      chk_stall("after_reset", 1'b0);
      check("after_reset_busy", 32'(MdBusy), 32'h0);
      tick();

      // Randomized triples against the reference model (unit idle here).
      have_s = 0; last_s = 0; last_len = 0; cyc = 0;
      for (int i = 0; i < 400; i++) begin
         rst_r = ($urandom_range(0, 39) != 0);
         cd = rnd_ins(); ce = rnd_ins(); cm = rnd_ins();
         set_in(cd.w, ce.w, cm.w, rst_r);
         busy_m = ce.md_start || (have_s && ((cyc - last_s) <= last_len));
         raw_m  = hit(ce.dest, ce.tnew_e, cd) || hit(cm.dest, cm.tnew_m, cd);
         @(negedge Clk);
         chk_stall("rnd", rst_r && (raw_m || (busy_m && cd.md_any)));
         check("rnd_busy", 32'(MdBusy), 32'(rst_r && busy_m));
         check("rnd_nomdu_stall", 32'(n_pauseF), 32'(rst_r && raw_m));
         check("rnd_nomdu_busy", 32'(n_mdBusy), 32'h0);
         if (!rst_r) begin
            have_s = 0;
         end else if (ce.md_start) begin
            have_s   = 1;
            last_s   = cyc;
            last_len = ce.is_div ? 10 : 5;
         end
         cyc++;
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Next-generation stall controller for the 5-stage MIPS pipeline (F/D/E/M/W). Generalises the D-stage pause unit in two ways:
  - Tuse/Tnew-based RAW hazard detection against the E and M stages.
  - A parametrised multi-cycle multiply/divide unit (MDU) busy tracker with its own countdown counter.
- Drives the F/D pipeline-register freeze and E-stage bubble insertion.
- Sits beside the D-stage decoder; consumes the instruction words held in the D, E and M pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E (1..2^CNT_W-1)
- DIV_CYCLES, 10, busy cycles after div/divu leaves E (1..2^CNT_W-1)
- CNT_W, 4, width of the MDU busy counter
- MDU_EN, 1, 0 = MDU tracking removed (counter tied 0, MdBusy=0)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- IRD  input  32  instruction in D stage
- IRE  input  32  instruction in E stage
- IRM  input  32  instruction in M stage
- PauseF  output  1  hold PC
- PauseD  output  1  hold F/D register
- ClearE  output  1  load nop into D/E register
- MdBusy  output  1  MDU busy (counter nonzero or start in E)

Behaviour:
- Reset is synchronous, active-low: at a rising Clk edge with Reset==0, cnt<=0.
- While Reset==0, PauseF, PauseD and ClearE are forced to 0, and MdBusy=0.
- Stall = RawStall | MdStall. PauseF = PauseD = ClearE = Stall. All three are combinational from IRD/IRE/IRM/cnt, with zero-cycle latency.
- Tuse of the D instruction, per source:
  - rs: 0 for beq, bne, jr, jalr; 1 for R-ALU, I-ALU, lw/sw base, mult/div, mthi/mtlo.
  - rt: 0 for beq, bne; 1 for R-ALU and mult/div; 2 for sw data.
  - Sources not read: Tuse = 3 (never stalls).
- Tnew for the E instruction: lw = 2; R-ALU, I-ALU, lui, mfhi, mflo = 1; jal = 0; non-writers = none.
- Tnew for the M instruction: lw = 1; all others = 0.
- Destination register:
  - rd for R-type writers.
  - rt for I-type writers and lw.
  - 31 for jal; rd for jalr.
  - Register 0 never matches.
- RawStall = OR over stage X in {E, M} and src in {rs, rt} of (dest_X==src && dest_X!=0 && Tnew_X > Tuse_src).
- MDU counter:
  - At an edge where IRE is mult/multu, cnt <= MULT_CYCLES. Where IRE is div/divu, cnt <= DIV_CYCLES.
  - Otherwise, if cnt != 0, cnt <= cnt-1.
  - A start always reloads, even if cnt != 0 (latest wins).
- Start = IRE is mult/multu/div/divu. MdBusy = start | (cnt != 0).
- MdStall = MdBusy && IRD is an MD-class instruction (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
- Stall effect on E: since ClearE bubbles E, a start in E lasts exactly one cycle. A stall caused by a start therefore never repeats the start.
- Cycle count: mflo in D behind mult in E stalls 1+MULT_CYCLES cycles.
- Reset mid-countdown: cnt cleared at that edge. No stall after Reset returns to 1 unless the IRs create one.
- Encoding rules: nop (0x00000000) has no destination and no sources. Unrecognised opcodes are treated as no-source, non-writer.

Decomposition:
- Package hazard_pkg:
  - opcode/funct constants: OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2b, OP_BEQ=6'h04, OP_BNE=6'h05, OP_JAL=6'h03, OP_LUI=6'h0f, OP_ORI=6'h0d, OP_ADDIU=6'h09; FN_MULT=6'h18, FN_MULTU=6'h19, FN_DIV=6'h1a, FN_DIVU=6'h1b, FN_MFHI=6'h10, FN_MFLO=6'h12, FN_MTHI=6'h11, FN_MTLO=6'h13, FN_JR=6'h08, FN_JALR=6'h09.
  - T_NONE=2'd3 and the Tuse/Tnew 2-bit type.
- Sub-module instr_class (combinational, instantiated 3x, once per stage). Outputs: rs, rt, dest, tuse_rs, tuse_rt, tnew_e, tnew_m, is_md_start, is_md_any.

Test Plan:
- Load-use: IRE=0x8C410000 (lw $1,0($2)), IRD=0x00241820 (add $3,$1,$4) → Stall=1. Next cycle IRE=0, IRM=lw, same IRD → Stall=0 (Tnew_M=1, Tuse=1).
- Branch hazard: IRE=0x00441021 (addu $2,$2,$4), IRD=0x10400003 (beq $2,$0) → Stall=1. Same with IRM=addu, IRE=0 → Stall=0.
- Store data: IRE=lw $5, IRD=0xACA50000 (sw $5,0($5)) → Stall=1 (base Tuse 1). IRD=0xAC050000 (sw $5,0($0)) → Stall=0 at E; with the lw in M instead → Stall=0.
- MDU: IRE=0x00220018 (mult $1,$2), IRD=0x00001812 (mflo $3) → Stall for exactly 6 cycles with default MULT_CYCLES. Same with div → 11 cycles. Non-MD IRD with cnt≠0 → Stall=0, MdBusy=1.
- Zero register: IRE=lw $0, IRD reading $0 → Stall=0.
- Reset: Reset=0 at cnt=7 → next edge cnt=0, all outputs 0 while Reset=0. Also verify MDU_EN=0 gives MdBusy=0 throughout.
